// File: rtl/mcp49x1_dac_sequencer.sv
// Multi-channel MCP49x1 (8/10/12-bit) DAC sequencer: on each sample_clk rising edge, snapshots all channels
// and streams them over a shared SCK/MOSI bus, one active-low chip select per enabled channel.
module mcp49x1_dac_sequencer #(
    parameter int NUM_CH  = 6,
    parameter int DATA_W  = 10,
    parameter int SCK_DIV = 4,
    parameter int CS_GAP  = 4,
    parameter bit BUF     = 1'b0,
    parameter bit GA_N    = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sample_clk,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     overrun_clr,
    output logic                     SCK_PIN,
    output logic                     MOSI_PIN,
    output logic [NUM_CH-1:0]        CS_PIN,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);
    // state  | meaning
    // IDLE   | waiting for a sample_clk rising edge
    // SELECT | pick lowest pending enabled channel, or finish
    // SETUP  | CS low, SCK low, first data bit on MOSI
    // SHIFT  | 16 SCK periods, MOSI changes on falling SCK
    // GAP    | all CS high between channels
    // DONE   | frame_done pulse; can also accept the next trigger
    localparam int CNT_MAX = (SCK_DIV > CS_GAP) ? SCK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    generate
        if (!(DATA_W == 8 || DATA_W == 10 || DATA_W == 12)) begin : g_bad_data_w
            $error("mcp49x1_dac_sequencer: DATA_W must be 8, 10 or 12");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state;
    logic                sclk_prev;
    logic [DATA_W-1:0]   data_snap [NUM_CH];
    logic [NUM_CH-1:0]   pend;
    logic [15:0]         word;
    logic [3:0]          bit_idx;
    logic [CNT_W-1:0]    cnt;

    logic                trig;
    logic                accept;
    logic                found;
    logic [CH_W-1:0]     sel;
    logic [11:0]         sel_data;
    logic [15:0]         sel_word;

    assign trig   = sample_clk & ~sclk_prev;
    assign accept = (state == S_IDLE) || (state == S_DONE);

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (pend[k]) begin
                found = 1'b1;
                sel   = CH_W'(k);
            end
        end
    end

    // Sample is left-justified into the 12-bit data field; unused LSBs are zero.
    assign sel_data = 12'(data_snap[sel]) << (12 - DATA_W);
    assign sel_word = {1'b0, BUF, GA_N, 1'b1, sel_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            sclk_prev  <= 1'b0;
            pend       <= '0;
            word       <= '0;
            bit_idx    <= '0;
            cnt        <= '0;
            SCK_PIN    <= 1'b0;
            MOSI_PIN   <= 1'b0;
            CS_PIN     <= '1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) data_snap[k] <= '0;
        end else begin
            sclk_prev <= sample_clk;

            if (trig && !accept) overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;

            if (trig && accept) begin
                pend <= ch_enable;
                for (int k = 0; k < NUM_CH; k++) data_snap[k] <= data_in[k*DATA_W +: DATA_W];
            end

            case (state)
                S_IDLE: begin
                    if (trig) begin
                        state <= S_SELECT;
                        busy  <= 1'b1;
                    end
                end
                S_SELECT: begin
                    if (found) begin
                        state     <= S_SETUP;
                        CS_PIN    <= ~(NUM_CH'(1) << sel);
                        SCK_PIN   <= 1'b0;
                        word      <= sel_word;
                        MOSI_PIN  <= sel_word[15];
                        pend[sel] <= 1'b0;
                        cnt       <= CNT_W'(SCK_DIV - 1);
                    end else begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        state   <= S_SHIFT;
                        SCK_PIN <= 1'b1;
                        bit_idx <= 4'd15;
                        cnt     <= CNT_W'(SCK_DIV - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (SCK_PIN) begin
                        SCK_PIN <= 1'b0;
                        cnt     <= CNT_W'(SCK_DIV - 1);
                        if (bit_idx != 4'd0) MOSI_PIN <= word[bit_idx - 4'd1];
                    end else if (bit_idx == 4'd0) begin
                        // Low phase after the last bit doubles as CS hold time.
                        state    <= S_GAP;
                        CS_PIN   <= '1;
                        MOSI_PIN <= 1'b0;
                        cnt      <= CNT_W'(CS_GAP - 1);
                    end else begin
                        bit_idx <= bit_idx - 4'd1;
                        SCK_PIN <= 1'b1;
                        cnt     <= CNT_W'(SCK_DIV - 1);
                    end
                end
                S_GAP: begin
                    if (cnt == '0) state <= S_SELECT;
                    else cnt <= cnt - 1'b1;
                end
                S_DONE: begin
                    frame_done <= 1'b0;
                    if (trig) begin
                        state <= S_SELECT;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
